// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder feeding the up/down counter's enable/direction pins.
// Optional glitch filter on the synchronised phases, enabled by QDEC_FILTER_EN.
module quad_step_decoder #(
  parameter int STEP_DIV   = 1,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       err_clr,
  output logic       enable,
  output logic       direction,
  output logic       err,
  output logic [7:0] err_cnt
);

  generate
    if (!(STEP_DIV == 1 || STEP_DIV == 2 || STEP_DIV == 4)) begin : g_bad_step_div
      $error("quad_step_decoder: STEP_DIV must be 1, 2 or 4");
    end
    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
      $error("quad_step_decoder: FILTER_LEN must be in 2..15");
    end
  endgenerate

  localparam logic signed [3:0] DIV_P = 4'(STEP_DIV);
  localparam logic signed [3:0] DIV_N = -DIV_P;

  logic [1:0]        a_sync_r;
  logic [1:0]        b_sync_r;
  logic [1:0]        syn_s;
  logic [1:0]        ab_s;
  logic [1:0]        prev_ab_r;
  logic signed [3:0] acc_r;
  logic signed [3:0] acc_nx_s;
  logic signed [3:0] sum_s;
  logic              fwd_s;
  logic              rev_s;
  logic              ill_s;
  logic              step_s;
  logic              dir_nx_s;

  // Two-flop synchronisers; bit 0 is stage 1, bit 1 is stage 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_r <= 2'b00;
      b_sync_r <= 2'b00;
    end else begin
      a_sync_r <= {a_sync_r[0], enc_a};
      b_sync_r <= {b_sync_r[0], enc_b};
    end
  end

  assign syn_s = {a_sync_r[1], b_sync_r[1]};

`ifdef QDEC_FILTER_EN
  localparam logic [3:0] FCNT_MAX = 4'(FILTER_LEN - 1);

  logic [1:0]      filt_r;
  logic [1:0][3:0] fcnt_r;

  // Per-phase glitch filter: a new level must persist FILTER_LEN cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r <= 2'b00;
      fcnt_r <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syn_s[i] != filt_r[i]) begin
          if (fcnt_r[i] == FCNT_MAX) begin
            filt_r[i] <= syn_s[i];
            fcnt_r[i] <= 4'd0;
          end else begin
            fcnt_r[i] <= fcnt_r[i] + 4'd1;
          end
        end else begin
          fcnt_r[i] <= 4'd0;
        end
      end
    end
  end

  assign ab_s = filt_r;
`else
  assign ab_s = syn_s;
`endif

  // Classify the AB transition as forward, reverse, illegal or none
  always_comb begin
    fwd_s = 1'b0;
    rev_s = 1'b0;
    ill_s = 1'b0;
    case ({prev_ab_r, ab_s})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd_s = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev_s = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill_s = 1'b1;
      default: begin
        fwd_s = 1'b0;
        rev_s = 1'b0;
        ill_s = 1'b0;
      end
    endcase
  end

  // Substep accumulation; a step fires when the sum reaches +/-STEP_DIV
  always_comb begin
    step_s   = 1'b0;
    dir_nx_s = direction;
    sum_s    = acc_r;
    acc_nx_s = acc_r;
    if (fwd_s) begin
      sum_s = acc_r + 4'sd1;
    end else if (rev_s) begin
      sum_s = acc_r - 4'sd1;
    end else begin
      sum_s = acc_r;
    end
    if (sum_s == DIV_P) begin
      step_s   = 1'b1;
      dir_nx_s = 1'b1;
      acc_nx_s = 4'sd0;
    end else if (sum_s == DIV_N) begin
      step_s   = 1'b1;
      dir_nx_s = 1'b0;
      acc_nx_s = 4'sd0;
    end else begin
      acc_nx_s = sum_s;
    end
  end

  // Decode state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_r <= 2'b00;
      acc_r     <= 4'sd0;
      enable    <= 1'b0;
      direction <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_ab_r <= ab_s;
      acc_r     <= acc_nx_s;
      enable    <= step_s;
      direction <= dir_nx_s;
      err       <= ill_s;
    end
  end

  // Saturating error count; clear takes priority over a coincident error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= 8'd0;
    end else if (ill_s && (err_cnt != 8'd255)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder (x4 and x1 instances).
// Filter scenarios are compiled in when QDEC_FILTER_EN is defined.
module tb_quad_step_decoder;

  localparam int FLEN = 4;
`ifdef QDEC_FILTER_EN
  localparam int LAT = 3 + FLEN;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       rst;
  logic       enc_a;
  logic       enc_b;
  logic       err_clr;
  logic       en1, dir1, err1;
  logic [7:0] cnt1;
  logic       en4, dir4, err4;
  logic [7:0] cnt4;

  int vectors;
  int miscompares;
  int pulses1, up1, dn1, errs1, first1, first_err1;
  int pulses4, up4, dn4;

  quad_step_decoder #(.STEP_DIV(1), .FILTER_LEN(FLEN)) dut1 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .enable(en1), .direction(dir1), .err(err1), .err_cnt(cnt1)
  );

  quad_step_decoder #(.STEP_DIV(4), .FILTER_LEN(FLEN)) dut4 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .enable(en4), .direction(dir4), .err(err4), .err_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {enc_a, enc_b} = 2'b00;
    err_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // Apply an AB level for n cycles and gather pulse statistics
  task automatic drive(input logic [1:0] ab, input int n);
    {enc_a, enc_b} = ab;
    pulses1 = 0; up1 = 0; dn1 = 0; errs1 = 0; first1 = -1; first_err1 = -1;
    pulses4 = 0; up4 = 0; dn4 = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (en1) begin
        pulses1++;
        if (first1 < 0) first1 = i;
        if (dir1) up1++; else dn1++;
      end
      if (err1) begin
        errs1++;
        if (first_err1 < 0) first_err1 = i;
      end
      if (en4) begin
        pulses4++;
        if (dir4) up4++; else dn4++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {enc_a, enc_b} = 2'b00;
    err_clr = 1'b0;
    #1;
    vectors++;
    if ({en1, dir1, err1, cnt1} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_x1: got en=%0b dir=%0b err=%0b cnt=%0d want all 0", en1, dir1, err1, cnt1);
    end
    vectors++;
    if ({en4, dir4, err4, cnt4} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_x4: got en=%0b dir=%0b err=%0b cnt=%0d want all 0", en4, dir4, err4, cnt4);
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(seq[k], 8);
      vectors++;
      if (pulses1 !== 1 || first1 !== LAT || up1 !== 1) begin
        miscompares++;
        $display("FAIL fwd_x4_edge%0d: got pulses=%0d at=%0d up=%0d want 1 at %0d up 1", k, pulses1, first1, up1, LAT);
      end
      vectors++;
      if (errs1 !== 0) begin
        miscompares++;
        $display("FAIL fwd_no_err%0d: got %0d err pulses want 0", k, errs1);
      end
      vectors++;
      if (up4 !== ((k == 3) ? 1 : 0) || dn4 !== 0) begin
        miscompares++;
        $display("FAIL fwd_x1_edge%0d: got up=%0d dn=%0d want up=%0d dn=0", k, up4, dn4, (k == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reverse();
    logic [1:0] seq [4];
    int tot_dn4, tot_up4;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    tot_dn4 = 0; tot_up4 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(seq[k], 8);
      tot_dn4 += dn4;
      tot_up4 += up4;
      vectors++;
      if (dn1 !== 1 || up1 !== 0) begin
        miscompares++;
        $display("FAIL rev_x4_edge%0d: got dn=%0d up=%0d want dn=1 up=0", k, dn1, up1);
      end
    end
    vectors++;
    if (tot_dn4 !== 1 || tot_up4 !== 0 || dir4 !== 1'b0) begin
      miscompares++;
      $display("FAIL rev_x1_cycle: got dn=%0d up=%0d dir=%0b want dn=1 up=0 dir=0", tot_dn4, tot_up4, dir4);
    end
    drive(2'b10, 8);
    tot_up4 = pulses4;
    drive(2'b00, 8);
    vectors++;
    if (tot_up4 + pulses4 !== 0 || dir4 !== 1'b0) begin
      miscompares++;
      $display("FAIL jitter_x1: got %0d pulses dir=%0b want 0 pulses dir=0", tot_up4 + pulses4, dir4);
    end
  endtask

  task automatic test_err();
    logic [1:0] ab;
    do_reset();
    drive(2'b11, 8);
    vectors++;
    if (errs1 !== 1 || first_err1 !== LAT || pulses1 !== 0 || cnt1 !== 8'd1) begin
      miscompares++;
      $display("FAIL illegal_jump: got errs=%0d at=%0d en=%0d cnt=%0d want 1 at %0d en 0 cnt 1",
               errs1, first_err1, pulses1, cnt1, LAT);
    end
    for (int i = 0; i < 253; i++) begin
      ab = (i % 2 == 0) ? 2'b00 : 2'b11;
      drive(ab, 8);
    end
    vectors++;
    if (cnt1 !== 8'd254) begin
      miscompares++;
      $display("FAIL err_cnt_254: got %0d want 254", cnt1);
    end
    for (int i = 253; i < 300; i++) begin
      ab = (i % 2 == 0) ? 2'b00 : 2'b11;
      drive(ab, 8);
    end
    vectors++;
    if (cnt1 !== 8'd255) begin
      miscompares++;
      $display("FAIL err_cnt_sat: got %0d want 255", cnt1);
    end
    {enc_a, enc_b} = 2'b00;
    repeat (LAT - 1) tick();
    err_clr = 1'b1;
    tick();
    vectors++;
    if (err1 !== 1'b1 || cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL clr_with_err: got err=%0b cnt=%0d want err=1 cnt=0", err1, cnt1);
    end
    err_clr = 1'b0;
    tick();
    vectors++;
    if (err1 !== 1'b0 || cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL after_clr: got err=%0b cnt=%0d want err=0 cnt=0", err1, cnt1);
    end
  endtask

`ifdef QDEC_FILTER_EN
  task automatic test_filter();
    do_reset();
    enc_a = 1'b1;
    repeat (3) tick();
    drive(2'b00, 12);
    vectors++;
    if (pulses1 !== 0 || errs1 !== 0) begin
      miscompares++;
      $display("FAIL glitch_suppress: got en=%0d err=%0d want 0 0", pulses1, errs1);
    end
    drive(2'b10, 10);
    vectors++;
    if (pulses1 !== 1 || first1 !== LAT || up1 !== 1) begin
      miscompares++;
      $display("FAIL filtered_step: got pulses=%0d at=%0d up=%0d want 1 at %0d up 1", pulses1, first1, up1, LAT);
    end
    drive(2'b00, 12);
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    drive(2'b11, 8);
    drive(2'b00, 8);
    drive(2'b10, 8);
    drive(2'b11, 8);
    drive(2'b01, 8);
    vectors++;
    if (cnt1 !== 8'd2 || dir1 !== 1'b1 || dir4 !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_state: got cnt=%0d dir1=%0b dir4=%0b want 2 1 0", cnt1, dir1, dir4);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({en1, dir1, err1, cnt1, en4, dir4, err4, cnt4} !== 22'd0) begin
      miscompares++;
      $display("FAIL async_reset: got cnt1=%0d dir1=%0b en1=%0b cnt4=%0d want all 0", cnt1, dir1, en1, cnt4);
    end
    tick();
    {enc_a, enc_b} = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    drive(2'b00, 6);
    drive(2'b10, 8);
    vectors++;
    if (pulses4 !== 0 || up1 !== 1) begin
      miscompares++;
      $display("FAIL discard_substeps: got x1 pulses=%0d x4 up=%0d want 0 and 1", pulses4, up1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_forward();
    test_reverse();
    test_err();
`ifdef QDEC_FILTER_EN
    test_filter();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage of the 4-bit up/down counter. Converts a two-phase quadrature encoder (A/B) into the counter's `enable` (single-cycle step pulse) and `direction` inputs.
- Provides input synchronisation, optional glitch filtering, step division and illegal-transition detection with a saturating error count.
- Outputs connect directly to the counter's `enable`/`direction` pins.

Parameters:
- STEP_DIV, 1, quadrature edges per emitted step; legal values 1, 2, 4 (x4/x2/x1 decoding).
- FILTER_LEN, 4, consecutive stable cycles required by the glitch filter; legal range 2..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- enc_a  input  1  encoder phase A, asynchronous to clk
- enc_b  input  1  encoder phase B, asynchronous to clk
- err_clr  input  1  synchronous clear of err_cnt
- enable  output  1  one-cycle step pulse to counter
- direction  output  1  1 = up, 0 = down; valid whenever enable=1, held otherwise
- err  output  1  one-cycle pulse on illegal transition
- err_cnt  output  8  saturating illegal-transition count

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. All flops clear immediately on rst=1 and leave reset on the first clk edge after deassertion.
- Reset values:
  - enable=0, direction=0, err=0, err_cnt=0.
  - Synchroniser flops, filter state, prev_ab register and substep accumulator all cleared to 0.
- Synchroniser: two flops per phase, giving 2-cycle latency.
- Filtered phases equal the synchronised phases when the filter is compiled out.
- Decode compares the current filtered AB against registered prev_ab every cycle:
  - Forward (up) sequence, AB order: 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse (down) sequence: the reverse order.
  - Unchanged AB: no action.
  - Both bits changed in the same cycle: illegal. Pulse err=1 for one cycle. No substep. Accumulator unchanged. prev_ab <= current AB.
  - prev_ab updates every cycle.
- Substep accumulator: signed, range -(STEP_DIV-1)..+(STEP_DIV-1).
  - Forward edge: add 1. Reverse edge: subtract 1.
  - Reaching +STEP_DIV: enable=1, direction=1, accumulator <= 0.
  - Reaching -STEP_DIV: enable=1, direction=0, accumulator <= 0.
  - Mixed forward/reverse edges cancel, so jitter on one edge emits no steps when STEP_DIV>1.
  - STEP_DIV=1: every legal edge emits a step.
- Latency (filter out): edges are named by when the AB change is first sampled.
  - E0: AB change sampled into sync stage 1.
  - E1: change reaches sync stage 2.
  - E2: enable/err registered high; stays high until E3.
  - Only one edge is processed per cycle, so enable is never high for two consecutive cycles unless the encoder really moves at clk/1.
- direction holds its last emitted value between pulses.
- err_cnt:
  - Increments on each err pulse and saturates at 255, holding there.
  - err_clr=1 sets err_cnt to 0 on the next edge.
  - err_clr and err in the same cycle: clear wins, err_cnt=0. The err pulse is still output.
- Reset mid-operation: any pending substeps are discarded. The first post-reset sample of AB (e.g. 11) is compared against prev_ab=00, which is illegal and produces one err.
  - This is required behaviour; the bench must tolerate it or hold AB=00 through reset.
- Out-of-range parameters are a design error. The implementation flags them with an elaboration-time check.

Optional Feature:
- Macro: QDEC_FILTER_EN.
- Defined:
  - Each synchronised phase feeds a glitch filter holding a filtered value plus a 4-bit stability counter.
  - When the synced value differs from the filtered value, the counter increments. The filtered value takes the new level when the counter reaches FILTER_LEN-1 while the difference persists, and the counter then clears.
  - Any cycle with synced == filtered clears the counter.
  - Pulses shorter than FILTER_LEN cycles are suppressed. Added latency is exactly FILTER_LEN cycles.
- Not defined: filter logic absent, FILTER_LEN ignored, latency 2 cycles sync + 1 cycle decode.

Test Plan:
- STEP_DIV=1, filter out; drive AB 00->10->11->01->00, each held 8 cycles -> 4 enable pulses, direction=1, each pulse 3 edges after its AB change, err never set.
- STEP_DIV=4; full reverse cycle 00->01->11->10->00 -> exactly 1 enable pulse with direction=0; then forward 00->10 and back 10->00 -> no pulse.
- Jump AB 00->11, held -> err=1 for one cycle, no enable, err_cnt=1; repeat 300 illegal jumps -> err_cnt=255 holds; assert err_clr together with an err pulse -> err_cnt=0.
- QDEC_FILTER_EN, FILTER_LEN=4:
  - A pulses high for 3 cycles -> no enable, no err.
  - A high for 10 cycles from AB=00 -> one up pulse, 4 cycles later than the unfiltered case.
- Assert rst asynchronously mid-sequence with accumulator at +3 (STEP_DIV=4) -> all outputs 0 immediately without a clock edge; one further forward edge after release -> no pulse.
